wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two result sources:
  - the in-order pipeline writeback stage (result mux output);
  - a long-latency side unit (multiplier/divider result return).
- Side-unit results are buffered in a small FIFO.
- The pipeline has priority. A starvation counter forces the side unit through after MAX_WAIT cycles, and the pipeline W stage is stalled for that cycle.
- Sits between writeback_cycle and the register file write port.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/wb_sync_fifo.sv | 67 ++++++
 rtl/wb_port_arbiter.sv | 107 ++++++++++
 tb/tb_wb_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core-wide widths and the writeback side-result entry type.
package riscv_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned WB_ENTRY_W = REG_ADDR_W + XLEN;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // x0 is hardwired to zero, so a write there is consumed but never enabled.
    function automatic logic rd_writes(input logic [REG_ADDR_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO for buffered side-unit results; power-of-two depth,
// asynchronous active-high reset clears pointers and occupancy.
module wb_sync_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 37
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO refuses a push even when it is popped the same cycle.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline W stage
// and buffered side-unit results, with a starvation bound on the side path.
module wb_port_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    RegWriteW,
    input  logic [REG_ADDR_W-1:0]   RDW,
    input  logic [XLEN-1:0]         ResultW,
    output logic                    StallW,
    input  logic                    lu_valid,
    input  logic [REG_ADDR_W-1:0]   lu_rd,
    input  logic [XLEN-1:0]         lu_data,
    output logic                    lu_ready,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_rd,
    output logic [XLEN-1:0]         rf_wd,
    output logic [$clog2(DEPTH):0]  lu_pending
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    logic [WB_ENTRY_W-1:0] head_raw;
    wb_entry_t             head;
    wb_entry_t             push_entry;
    logic                  fifo_full, fifo_empty;
    logic                  side_gnt, pipe_gnt, starved;

    logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]       rf_wd_q, rf_wd_d;

    assign push_entry = '{rd: lu_rd, data: lu_data};
    assign head       = wb_entry_t'(head_raw);

    // Readiness depends only on registered occupancy, never on this cycle's valids.
    assign lu_ready = ~fifo_full;

    wb_sync_fifo #(
        .Depth (DEPTH),
        .Width (WB_ENTRY_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (lu_valid & lu_ready),
        .wdata_i (push_entry),
        .pop_i   (side_gnt),
        .rdata_o (head_raw),
        .count_o (lu_pending),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign starved  = (wait_cnt_q >= WaitW'(MAX_WAIT));
    assign side_gnt = ~fifo_empty & (~RegWriteW | starved);
    assign pipe_gnt = RegWriteW & ~side_gnt;
    assign StallW   = RegWriteW & side_gnt;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (fifo_empty || side_gnt) begin
            wait_cnt_d = '0;
        end else if (!starved) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
    end

    // Without a grant the address/data hold so the port does not toggle needlessly.
    always_comb begin
        rf_we_d = 1'b0;
        rf_rd_d = rf_rd_q;
        rf_wd_d = rf_wd_q;
        if (side_gnt) begin
            rf_we_d = rd_writes(head.rd);
            rf_rd_d = head.rd;
            rf_wd_d = head.data;
        end else if (pipe_gnt) begin
            rf_we_d = rd_writes(RDW);
            rf_rd_d = RDW;
            rf_wd_d = ResultW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wd_q    <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wd_q    <= rf_wd_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_rd = rf_rd_q;
    assign rf_wd = rf_wd_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, async reset check, and a
// randomized phase scored against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        StallW;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic [1:0]  lu_pending;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteW  (RegWriteW),
        .RDW        (RDW),
        .ResultW    (ResultW),
        .StallW     (StallW),
        .lu_valid   (lu_valid),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wd      (rf_wd),
        .lu_pending (lu_pending)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  rdw;
        logic [31:0] res;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        stall;
        logic        ready;
        logic [1:0]  pend;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
    } exp_t;

    localparam int NV = 30;
    vec_t tv [NV];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    function automatic vec_t mk(input logic rw, input logic [4:0] rdw, input logic [31:0] res,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                input logic stall, input logic ready, input logic [1:0] pend,
                                input logic we, input logic [4:0] rd, input logic [31:0] wd);
        vec_t v;
        v.rw = rw; v.rdw = rdw; v.res = res; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.stall = stall; v.ready = ready; v.pend = pend; v.we = we; v.rd = rd; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rw, input logic [4:0] rdw, input logic [31:0] res,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        RegWriteW = rw; RDW = rdw; ResultW = res;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
    endtask

    // Reference model state for the randomized phase.
    ent_t        mq[$];
    exp_t        sb[$];
    int          mwait;
    logic [4:0]  last_rd;
    logic [31:0] last_wd;

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        chk("reset_pending", 32'(lu_pending), 32'd0);
        chk("reset_ready",   32'(lu_ready),   32'd1);
        chk("reset_stall",   32'(StallW),     32'd0);
        chk("reset_we",      32'(rf_we),      32'd0);

        //      rw rdw   res            lv lrd   ld            st rdy pd we rd    wd
        tv[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0, 1, 0, 0, 5'd0,  32'h0);
        tv[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0, 1, 5'd5,  32'hDEADBEEF);
        tv[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0, 0, 5'd5,  32'hDEADBEEF);
        tv[3]  = mk(0, 5'd0,  32'h0,        1, 5'd7,  32'h12345678, 0, 1, 0, 0, 5'd5,  32'hDEADBEEF);
        tv[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 1, 0, 5'd5,  32'hDEADBEEF);
        tv[5]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0, 1, 5'd7,  32'h12345678);
        tv[6]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0, 0, 5'd7,  32'h12345678);
        tv[7]  = mk(1, 5'd1,  32'hA0000001, 1, 5'd9,  32'h99,       0, 1, 0, 0, 5'd7,  32'h12345678);
        tv[8]  = mk(1, 5'd2,  32'hA0000002, 0, 5'd0,  32'h0,        0, 1, 1, 1, 5'd1,  32'hA0000001);
        tv[9]  = mk(1, 5'd3,  32'hA0000003, 0, 5'd0,  32'h0,        0, 1, 1, 1, 5'd2,  32'hA0000002);
        tv[10] = mk(1, 5'd4,  32'hA0000004, 0, 5'd0,  32'h0,        0, 1, 1, 1, 5'd3,  32'hA0000003);
        tv[11] = mk(1, 5'd5,  32'hA0000005, 0, 5'd0,  32'h0,        0, 1, 1, 1, 5'd4,  32'hA0000004);
        tv[12] = mk(1, 5'd6,  32'hA0000006, 0, 5'd0,  32'h0,        1, 1, 1, 1, 5'd5,  32'hA0000005);
        tv[13] = mk(1, 5'd6,  32'hA0000006, 0, 5'd0,  32'h0,        0, 1, 0, 1, 5'd9,  32'h99);
        tv[14] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0, 1, 5'd6,  32'hA0000006);
        tv[15] = mk(1, 5'd10, 32'hB0000000, 1, 5'd11, 32'hC0000001, 0, 1, 0, 0, 5'd6,  32'hA0000006);
        tv[16] = mk(1, 5'd12, 32'hB0000001, 1, 5'd13, 32'hC0000002, 0, 1, 1, 1, 5'd10, 32'hB0000000);
        tv[17] = mk(1, 5'd14, 32'hB0000002, 1, 5'd15, 32'hC0000003, 0, 0, 2, 1, 5'd12, 32'hB0000001);
        tv[18] = mk(1, 5'd16, 32'hB0000003, 1, 5'd15, 32'hC0000003, 0, 0, 2, 1, 5'd14, 32'hB0000002);
        tv[19] = mk(1, 5'd17, 32'hB0000004, 1, 5'd15, 32'hC0000003, 0, 0, 2, 1, 5'd16, 32'hB0000003);
        tv[20] = mk(1, 5'd18, 32'hB0000005, 1, 5'd15, 32'hC0000003, 1, 0, 2, 1, 5'd17, 32'hB0000004);
        tv[21] = mk(1, 5'd18, 32'hB0000005, 1, 5'd15, 32'hC0000003, 0, 1, 1, 1, 5'd11, 32'hC0000001);
        tv[22] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 2, 1, 5'd18, 32'hB0000005);
        tv[23] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 1, 1, 5'd13, 32'hC0000002);
        tv[24] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0, 1, 5'd15, 32'hC0000003);
        tv[25] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0, 0, 5'd15, 32'hC0000003);
        tv[26] = mk(1, 5'd0,  32'hE0000000, 1, 5'd0,  32'hE0000001, 0, 1, 0, 0, 5'd15, 32'hC0000003);
        tv[27] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 1, 0, 5'd0,  32'hE0000000);
        tv[28] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0, 0, 5'd0,  32'hE0000001);
        tv[29] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 1, 0, 0, 5'd0,  32'hE0000001);

        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive(tv[i].rw, tv[i].rdw, tv[i].res, tv[i].lv, tv[i].lrd, tv[i].ld);
            #3;
            chk($sformatf("v%0d_stall", i), 32'(StallW),     32'(tv[i].stall));
            chk($sformatf("v%0d_ready", i), 32'(lu_ready),   32'(tv[i].ready));
            chk($sformatf("v%0d_pend", i),  32'(lu_pending), 32'(tv[i].pend));
            chk($sformatf("v%0d_we", i),    32'(rf_we),      32'(tv[i].we));
            chk($sformatf("v%0d_rd", i),    32'(rf_rd),      32'(tv[i].rd));
            chk($sformatf("v%0d_wd", i),    rf_wd,           tv[i].wd);
        end

        // Asynchronous reset in the middle of traffic with two entries buffered.
        @(posedge clk); #1;
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        @(posedge clk); #1;
        drive(1'b1, 5'd3, 32'h34, 1'b1, 5'd5, 32'h55);
        @(posedge clk); #1;
        drive(1'b1, 5'd3, 32'h35, 1'b0, 5'd0, 32'h0);
        #1;
        chk("pre_rst_pending", 32'(lu_pending), 32'd2);
        chk("pre_rst_we",      32'(rf_we),      32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_pending", 32'(lu_pending), 32'd0);
        chk("mid_rst_we",      32'(rf_we),      32'd0);
        chk("mid_rst_rd",      32'(rf_rd),      32'd0);
        chk("mid_rst_wd",      rf_wd,           32'd0);
        chk("mid_rst_ready",   32'(lu_ready),   32'd1);
        chk("mid_rst_stall",   32'(StallW),     32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic against the reference model.
        mwait   = 0;
        last_rd = '0;
        last_wd = '0;
        begin
            logic hold_pipe = 1'b0;
            logic hold_lu   = 1'b0;
            for (int c = 0; c < 400; c++) begin
                logic m_ready, nonempty, side, pipe;
                exp_t e;
                @(posedge clk); #1;
                if (!hold_pipe) begin
                    RegWriteW = ($urandom_range(0, 9) < 7);
                    RDW       = 5'($urandom);
                    ResultW   = $urandom;
                end
                if (!hold_lu) begin
                    lu_valid = ($urandom_range(0, 9) < 4);
                    lu_rd    = 5'($urandom);
                    lu_data  = $urandom;
                end
                #3;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk($sformatf("r%0d_we", c), 32'(rf_we), 32'(e.we));
                    chk($sformatf("r%0d_rd", c), 32'(rf_rd), 32'(e.rd));
                    chk($sformatf("r%0d_wd", c), rf_wd,      e.wd);
                end
                m_ready  = (mq.size() < DEPTH);
                nonempty = (mq.size() > 0);
                side     = nonempty && (!RegWriteW || mwait >= MAX_WAIT);
                pipe     = RegWriteW && !side;
                chk($sformatf("r%0d_ready", c), 32'(lu_ready),   32'(m_ready));
                chk($sformatf("r%0d_pend", c),  32'(lu_pending), 32'(mq.size()));
                chk($sformatf("r%0d_stall", c), 32'(StallW),     32'(RegWriteW && side));
                if (side) begin
                    e.we = (mq[0].rd != 5'd0); e.rd = mq[0].rd; e.wd = mq[0].d;
                end else if (pipe) begin
                    e.we = (RDW != 5'd0); e.rd = RDW; e.wd = ResultW;
                end else begin
                    e.we = 1'b0; e.rd = last_rd; e.wd = last_wd;
                end
                last_rd = e.rd;
                last_wd = e.wd;
                sb.push_back(e);
                if (!nonempty || side) mwait = 0;
                else if (mwait < MAX_WAIT) mwait++;
                if (side) void'(mq.pop_front());
                if (lu_valid && m_ready) mq.push_back('{rd: lu_rd, d: lu_data});
                hold_pipe = RegWriteW && side;
                hold_lu   = lu_valid && !m_ready;
            end
        end

        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #3;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("tail_we", 32'(rf_we), 32'(e.we));
            chk("tail_rd", 32'(rf_rd), 32'(e.rd));
            chk("tail_wd", rf_wd,      e.wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
